// File: rtl/lcd1602_rx_model.sv
// HD44780-compatible receiver for the 16x2 LCD parallel bus: decodes command and data writes,
// keeps the 80-byte DDRAM image and exposes controller status plus a registered character readback.
module lcd1602_rx_model #(
    parameter int unsigned DROP_W    = 8,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic              clk_LCD,
    input  logic              rst,
    input  logic              lcd_en,
    input  logic              lcd_rs,
    input  logic              lcd_rw,
    input  logic [7:0]        lcd_data,
    input  logic [6:0]        rd_addr,
    output logic [7:0]        rd_char,
    output logic [6:0]        ac,
    output logic              busy,
    output logic              disp_on,
    output logic              cursor_on,
    output logic              blink_on,
    output logic              two_line,
    output logic              proto_err,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int unsigned AW       = 7;
    localparam int unsigned DW       = 8;
    localparam int unsigned DEPTH    = 80;
    localparam int unsigned LINE_LEN = 40;

    localparam logic [AW-1:0] LINE1_END  = 7'h27;
    localparam logic [AW-1:0] LINE2_BASE = 7'h40;
    localparam logic [AW-1:0] LINE2_END  = 7'h67;

    typedef enum logic {
        ST_CLR,
        ST_IDLE
    } state_t;

    state_t            state, state_n;
    logic [AW-1:0]     clr_idx, clr_idx_n;
    logic [AW-1:0]     ac_n;
    logic              inc_mode, inc_n;
    logic              cg_mode, cg_n;
    logic              disp_n, cursor_n, blink_n, two_n;
    logic              perr_n, busy_n;
    logic [DROP_W-1:0] drop_n;

    logic              mem_we_c;
    logic [AW-1:0]     mem_wa_c;
    logic [DW-1:0]     mem_wd_c;
    logic [DW-1:0]     mem [DEPTH];

    // Each line occupies the low 40 slots of its 64-entry half of the address space.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return a[5:0] < 6'(LINE_LEN);
    endfunction

    function automatic logic [AW-1:0] addr_idx(input logic [AW-1:0] a);
        return a[6] ? AW'(a[5:0]) + AW'(LINE_LEN) : AW'(a[5:0]);
    endfunction

    // Address counter moves line1 -> line2 -> line1 in both directions.
    function automatic logic [AW-1:0] ac_step(input logic [AW-1:0] a, input logic up);
        logic [AW-1:0] r;
        if (up) begin
            r = (a == LINE1_END) ? LINE2_BASE : (a == LINE2_END) ? '0 : a + AW'(1);
        end else begin
            r = (a == '0) ? LINE2_END : (a == LINE2_BASE) ? LINE1_END : a - AW'(1);
        end
        return r;
    endfunction

    // State and status registers.
    always_ff @(posedge clk_LCD or negedge rst) begin
        if (!rst) begin
            state     <= ST_CLR;
            clr_idx   <= '0;
            ac        <= '0;
            inc_mode  <= 1'b1;
            cg_mode   <= 1'b0;
            disp_on   <= 1'b0;
            cursor_on <= 1'b0;
            blink_on  <= 1'b0;
            two_line  <= 1'b0;
            proto_err <= 1'b0;
            busy      <= 1'b1;
            drop_cnt  <= '0;
        end else begin
            state     <= state_n;
            clr_idx   <= clr_idx_n;
            ac        <= ac_n;
            inc_mode  <= inc_n;
            cg_mode   <= cg_n;
            disp_on   <= disp_n;
            cursor_on <= cursor_n;
            blink_on  <= blink_n;
            two_line  <= two_n;
            proto_err <= perr_n;
            busy      <= busy_n;
            drop_cnt  <= drop_n;
        end
    end

    // Next-state, transfer decode and DDRAM write port.
    always_comb begin
        state_n   = state;
        clr_idx_n = clr_idx;
        ac_n      = ac;
        inc_n     = inc_mode;
        cg_n      = cg_mode;
        disp_n    = disp_on;
        cursor_n  = cursor_on;
        blink_n   = blink_on;
        two_n     = two_line;
        drop_n    = drop_cnt;
        perr_n    = 1'b0;
        mem_we_c  = 1'b0;
        mem_wa_c  = '0;
        mem_wd_c  = '0;

        case (state)
            ST_CLR: begin
                mem_we_c = 1'b1;
                mem_wa_c = clr_idx;
                mem_wd_c = FILL_CHAR;
                if (clr_idx == AW'(DEPTH - 1)) begin
                    state_n   = ST_IDLE;
                    clr_idx_n = '0;
                end else begin
                    clr_idx_n = clr_idx + AW'(1);
                end
                if (lcd_en && (drop_cnt != '1)) begin
                    drop_n = drop_cnt + DROP_W'(1);
                end
            end
            ST_IDLE: begin
                if (lcd_en) begin
                    if (lcd_rw) begin
                        perr_n = 1'b1;
                    end else if (lcd_rs) begin
                        if (!cg_mode) begin
                            mem_we_c = 1'b1;
                            mem_wa_c = addr_idx(ac);
                            mem_wd_c = lcd_data;
                            ac_n     = ac_step(ac, inc_mode);
                        end
                    end else begin
                        casez (lcd_data)
                            8'b1???????: begin
                                if (addr_ok(lcd_data[6:0])) begin
                                    ac_n = lcd_data[6:0];
                                    cg_n = 1'b0;
                                end else begin
                                    perr_n = 1'b1;
                                end
                            end
                            8'b01??????: cg_n = 1'b1;
                            8'b001?????: two_n = lcd_data[3];
                            8'b0001????: begin
                                if (!lcd_data[3]) begin
                                    ac_n = ac_step(ac, lcd_data[2]);
                                end
                            end
                            8'b00001???: {disp_n, cursor_n, blink_n} = lcd_data[2:0];
                            8'b000001??: inc_n = lcd_data[1];
                            8'b0000001?: ac_n = '0;
                            8'b00000001: begin
                                state_n   = ST_CLR;
                                clr_idx_n = '0;
                                ac_n      = '0;
                                inc_n     = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_n = ST_CLR;
        endcase

        busy_n = (state_n == ST_CLR);
    end

    // DDRAM storage; contents are defined by the clear that follows every reset.
    always_ff @(posedge clk_LCD) begin
        if (mem_we_c) begin
            mem[mem_wa_c] <= mem_wd_c;
        end
    end

    // Registered readback; holes in the address map read as zero.
    always_ff @(posedge clk_LCD or negedge rst) begin
        if (!rst) begin
            rd_char <= '0;
        end else begin
            rd_char <= addr_ok(rd_addr) ? mem[addr_idx(rd_addr)] : '0;
        end
    end

endmodule

// File: tb/tb_lcd1602_rx_model.sv
// Bench for lcd1602_rx_model: directed bring-up scenarios plus randomized traffic checked
// against a linear-position model of the 80-character display memory.
module tb_lcd1602_rx_model;

    logic       clk_LCD = 1'b0;
    logic       rst = 1'b0;
    logic       lcd_en = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic [7:0] lcd_data = '0;
    logic [6:0] rd_addr = '0;
    logic [7:0] rd_char;
    logic [6:0] ac;
    logic       busy, disp_on, cursor_on, blink_on, two_line, proto_err;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [7:0] m_mem [128];
    int m_ac, m_inc, m_cg, m_disp, m_cur, m_blink, m_two, m_drop;
    int m_clr_left, m_clr_pos, m_perr, m_rd;

    always #5 clk_LCD = ~clk_LCD;

    lcd1602_rx_model #(.DROP_W(8), .FILL_CHAR(8'h20)) dut (
        .clk_LCD(clk_LCD), .rst(rst), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char), .ac(ac), .busy(busy),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .two_line(two_line),
        .proto_err(proto_err), .drop_cnt(drop_cnt)
    );

    function automatic bit m_valid(int a);
        return (a % 64) < 40;
    endfunction

    function automatic int pos_to_addr(int p);
        return (p < 40) ? p : 64 + (p - 40);
    endfunction

    function automatic int addr_to_pos(int a);
        return (a < 64) ? a : 40 + (a - 64);
    endfunction

    // The 80 cells form one ring in display order.
    function automatic int m_step(int a, int up);
        int p;
        p = addr_to_pos(a);
        p = (up != 0) ? (p + 1) % 80 : (p + 79) % 80;
        return pos_to_addr(p);
    endfunction

    task automatic model_reset();
        m_ac = 0; m_inc = 1; m_cg = 0; m_disp = 0; m_cur = 0; m_blink = 0; m_two = 0;
        m_drop = 0; m_clr_left = 80; m_clr_pos = 0; m_perr = 0; m_rd = 0;
    endtask

    task automatic model_edge(int en, int rs, int rw, int d, int ra);
        m_rd = m_valid(ra) ? int'(m_mem[ra]) : 0;
        m_perr = 0;
        if (m_clr_left > 0) begin
            if (en != 0 && m_drop < 255) m_drop++;
            m_mem[pos_to_addr(m_clr_pos)] = 8'h20;
            m_clr_pos++;
            m_clr_left--;
        end else if (en != 0) begin
            if (rw != 0) m_perr = 1;
            else if (rs != 0) begin
                if (m_cg == 0) begin
                    m_mem[m_ac] = 8'(d);
                    m_ac = m_step(m_ac, m_inc);
                end
            end else if (d >= 128) begin
                if (m_valid(d - 128)) begin m_ac = d - 128; m_cg = 0; end
                else m_perr = 1;
            end else if (d >= 64) m_cg = 1;
            else if (d >= 32) m_two = (d / 8) % 2;
            else if (d >= 16) begin
                if ((d / 8) % 2 == 0) m_ac = m_step(m_ac, (d / 4) % 2);
            end else if (d >= 8) begin
                m_disp = (d / 4) % 2; m_cur = (d / 2) % 2; m_blink = d % 2;
            end else if (d >= 4) m_inc = (d / 2) % 2;
            else if (d >= 2) m_ac = 0;
            else if (d == 1) begin
                m_clr_left = 80; m_clr_pos = 0; m_ac = 0; m_inc = 1;
            end
        end
    endtask

    task automatic cycle(int en, int rs, int rw, int d, int ra);
        lcd_en = 1'(en); lcd_rs = 1'(rs); lcd_rw = 1'(rw);
        lcd_data = 8'(d); rd_addr = 7'(ra);
        model_edge(en, rs, rw, d, ra);
        @(posedge clk_LCD);
        #1;
        lcd_en = 1'b0;
    endtask

    task automatic cmd(int d);  cycle(1, 0, 0, d, 0); endtask
    task automatic wr(int d);   cycle(1, 1, 0, d, 0); endtask
    task automatic rd(int a);   cycle(0, 0, 0, 0, a); endtask
    task automatic idle(int n); for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0); endtask

    task automatic test_reset();
        int n;
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_LCD);
        #1;
        total++;
        if ({ac, busy, proto_err, drop_cnt, disp_on, cursor_on, blink_on, two_line, rd_char} !==
            {7'h00, 1'b1, 1'b0, 8'h00, 4'b0000, 8'h00}) begin
            bad++;
            $display("FAIL reset_values: got ac=%0h busy=%0b perr=%0b drop=%0d ctl=%0b%0b%0b%0b rd=%0h",
                     ac, busy, proto_err, drop_cnt, disp_on, cursor_on, blink_on, two_line, rd_char);
        end
        rst = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 200) begin idle(1); n++; end
        total++;
        if (n != 80) begin bad++; $display("FAIL reset_busy_len: got %0d want 80", n); end
    endtask

    task automatic test_init();
        string s, e;
        s = "   GAME START   ";
        e = "GAME START";
        cmd(8'h01);
        idle(80);
        cmd(8'h38); cmd(8'h0C); cmd(8'h06); cmd(8'h80);
        for (int i = 0; i < 16; i++) wr(int'(s[i]));
        total++;
        if ({ac, disp_on, cursor_on, blink_on, two_line} !== {7'h10, 4'b1001}) begin
            bad++;
            $display("FAIL init_status: got ac=%0h disp=%0b cur=%0b blink=%0b two=%0b want ac=10 1 0 0 1",
                     ac, disp_on, cursor_on, blink_on, two_line);
        end
        for (int i = 0; i < 10; i++) begin
            rd(3 + i);
            total++;
            if (rd_char !== 8'(e[i])) begin
                bad++;
                $display("FAIL init_text[%0h]: got %0h want %0h", 3 + i, rd_char, 8'(e[i]));
            end
        end
    endtask

    task automatic test_line2();
        string s, e;
        s = "     TIMING: 07s";
        e = "TIMING: 07s";
        cmd(8'hC0);
        for (int i = 0; i < 16; i++) wr(int'(s[i]));
        total++;
        if (ac !== 7'h50) begin bad++; $display("FAIL line2_ac: got %0h want 50", ac); end
        for (int i = 0; i < 11; i++) begin
            rd(8'h45 + i);
            total++;
            if (rd_char !== 8'(e[i])) begin
                bad++;
                $display("FAIL line2_text[%0h]: got %0h want %0h", 8'h45 + i, rd_char, 8'(e[i]));
            end
        end
    endtask

    task automatic test_wrap();
        cmd(8'hA7); wr(8'h41); wr(8'h42);
        rd(8'h27);
        total++;
        if (rd_char !== 8'h41) begin bad++; $display("FAIL wrap_up_27: got %0h want 41", rd_char); end
        rd(8'h40);
        total++;
        if (rd_char !== 8'h42) begin bad++; $display("FAIL wrap_up_40: got %0h want 42", rd_char); end
        cmd(8'h04); cmd(8'hC0); wr(8'h43); wr(8'h44);
        total++;
        if (ac !== 7'h26) begin bad++; $display("FAIL wrap_down_ac: got %0h want 26", ac); end
        rd(8'h27);
        total++;
        if (rd_char !== 8'h44) begin bad++; $display("FAIL wrap_down_27: got %0h want 44", rd_char); end
        rd(8'h40);
        total++;
        if (rd_char !== 8'h43) begin bad++; $display("FAIL wrap_down_40: got %0h want 43", rd_char); end
        cmd(8'h06);
    endtask

    task automatic test_busy_drop();
        logic [7:0] exp;
        cmd(8'h01);
        for (int i = 0; i < 5; i++) wr(int'($urandom_range(33, 126)));
        idle(75);
        total++;
        if ({busy, drop_cnt} !== {1'b0, 8'd5}) begin
            bad++;
            $display("FAIL drop_count: got busy=%0b drop=%0d want busy=0 drop=5", busy, drop_cnt);
        end
        wr(8'h5A);
        for (int a = 0; a < 128; a++) begin
            rd(a);
            exp = (a == 0) ? 8'h5A : (m_valid(a) ? 8'h20 : 8'h00);
            total++;
            if (rd_char !== exp) begin
                bad++;
                $display("FAIL drop_fill[%0h]: got %0h want %0h", a, rd_char, exp);
            end
        end
    endtask

    task automatic test_proto();
        int a0, pulses;
        logic [7:0] c0;
        a0 = m_ac;
        c0 = m_mem[a0];
        pulses = 0;
        cmd(8'hA8);
        pulses += int'(proto_err === 1'b1);
        cycle(1, 0, 1, 8'h33, 0);
        pulses += int'(proto_err === 1'b1);
        cmd(8'h40);
        pulses += int'(proto_err === 1'b1);
        wr(8'h55);
        pulses += int'(proto_err === 1'b1);
        total++;
        if (pulses != 2) begin bad++; $display("FAIL proto_pulses: got %0d want 2", pulses); end
        total++;
        if (ac !== 7'(a0)) begin bad++; $display("FAIL proto_ac: got %0h want %0h", ac, a0); end
        rd(a0);
        total++;
        if (rd_char !== c0) begin bad++; $display("FAIL proto_mem: got %0h want %0h", rd_char, c0); end
        cmd(8'h80 + a0);
    endtask

    task automatic test_random();
        int en, rs, rw, d, ra;
        logic [28:0] obs, exp;
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 3) != 0) ? 1 : 0;
            rs = int'($urandom_range(0, 1));
            rw = ($urandom_range(0, 19) == 0) ? 1 : 0;
            d  = ($urandom_range(0, 39) == 0) ? 1 : int'($urandom_range(2, 255));
            ra = int'($urandom_range(0, 127));
            cycle(en, rs, rw, d, ra);
            obs = {ac, busy, proto_err, drop_cnt, disp_on, cursor_on, blink_on, two_line, rd_char};
            exp = {7'(m_ac), (m_clr_left > 0), 1'(m_perr), 8'(m_drop), 1'(m_disp), 1'(m_cur),
                   1'(m_blink), 1'(m_two), 8'(m_rd)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL random[%0d] {ac,busy,perr,drop,ctl,rd}: got %07h want %07h", i, obs, exp);
            end
        end
        idle(90);
    endtask

    task automatic test_reset_mid_clear();
        int n;
        logic [7:0] exp;
        cmd(8'h01);
        idle(39);
        rst = 1'b0;
        #1;
        total++;
        if ({ac, busy, proto_err, drop_cnt, disp_on, cursor_on, blink_on, two_line, rd_char} !==
            {7'h00, 1'b1, 1'b0, 8'h00, 4'b0000, 8'h00}) begin
            bad++;
            $display("FAIL midclr_reset: got ac=%0h busy=%0b perr=%0b drop=%0d ctl=%0b%0b%0b%0b rd=%0h",
                     ac, busy, proto_err, drop_cnt, disp_on, cursor_on, blink_on, two_line, rd_char);
        end
        model_reset();
        @(posedge clk_LCD);
        #1;
        rst = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 200) begin idle(1); n++; end
        total++;
        if (n != 80) begin bad++; $display("FAIL midclr_busy_len: got %0d want 80", n); end
        for (int a = 0; a < 128; a++) begin
            rd(a);
            exp = m_valid(a) ? 8'h20 : 8'h00;
            total++;
            if (rd_char !== exp) begin
                bad++;
                $display("FAIL midclr_fill[%0h]: got %0h want %0h", a, rd_char, exp);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) m_mem[i] = 8'h00;
        test_reset();
        test_init();
        test_line2();
        test_wrap();
        test_busy_drop();
        test_proto();
        test_random();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd1602_rx_model.md
# lcd1602_rx_model

Receiving end of the 16x2 character-LCD parallel bus: an HD44780-compatible responder that decodes command/data writes, maintains an 80-byte DDRAM image, and exposes controller status plus a character readback port. It sits on the LCD bus beside (or in place of) the physical panel. The snake game bench and the on-chip debug path use it to check the on-screen text, such as "GAME START" or "TIMING: 07s", without a physical display.

## Interface
- DROP_W, 8: width of the saturating dropped-transfer counter
- FILL_CHAR, 8'h20: byte written to every location by a clear

- clk_LCD  in  1  bus clock; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- lcd_en  in  1  transfer-valid level, synchronous to clk_LCD (never the clock-gated pin)
- lcd_rs  in  1  0 = command, 1 = data
- lcd_rw  in  1  0 = write, 1 = read (unsupported)
- lcd_data  in  8  command or character byte
- rd_addr  in  7  DDRAM readback address
- rd_char  out  8  registered DDRAM[rd_addr]
- ac  out  7  address counter
- busy  out  1  clear in progress; transfers are dropped while high
- disp_on, cursor_on, blink_on  out  1 each  display-control bits
- two_line  out  1  function-set N bit
- proto_err  out  1  one-cycle pulse on an illegal transfer
- drop_cnt  out  DROP_W  count of transfers rejected while busy, saturating

## Operation
- A transfer commits on a rising edge where lcd_en=1. Nothing happens on edges where lcd_en=0.
- DDRAM layout:
  - Line 1 at 0x00–0x27, line 2 at 0x40–0x67, 80 bytes total.
  - Visible window is 0x00–0x0F and 0x40–0x4F.
- Addresses 0x28–0x3F and 0x68–0x7F are invalid.
  - rd_char returns 8'h00 for these.
- FSM states: CLR and IDLE.
  - Reset enters CLR, so DDRAM is defined without an explicit clear.
  - CLR writes FILL_CHAR to one location per cycle using an internal index 0..79, then returns to IDLE.
  - busy=1 exactly while in CLR.
- Transfers committed while busy:
  - The transfer is ignored.
  - drop_cnt increments and saturates at all-ones.
- Command decode in IDLE (rs=0, rw=0), by highest set bit:
  - 0x01 clear: enter CLR, ac=0, I/D=1.
  - 0x02/0x03 return home: ac=0.
  - 0x04–0x07 entry mode: I/D=data[1]. The S bit is ignored.
  - 0x08–0x0F display control: disp_on=d[2], cursor_on=d[1], blink_on=d[0].
  - 0x10–0x1F shift: if d[3]=0, move ac one step (right when d[2]=1, else left). Display shift is ignored.
  - 0x20–0x3F function set: two_line=d[3]. The DL and F bits are ignored.
  - 0x40–0x7F CGRAM address: set cg_mode. While cg_mode is set, following data writes are discarded.
  - 0x80–0xFF: if d[6:0] is valid, set ac=d[6:0] and clear cg_mode. If invalid, pulse proto_err and leave ac unchanged.
- Data write (rs=1, rw=0, cg_mode=0):
  - DDRAM[ac] <= lcd_data.
  - ac then steps in the I/D direction.
- Address stepping:
  - Increment: 0x27→0x40 and 0x67→0x00.
  - Decrement: 0x00→0x67 and 0x40→0x27.
- A committed transfer with rw=1 pulses proto_err and has no other effect.
- Reset values:
  - Outputs: ac=0, disp_on=0, cursor_on=0, blink_on=0, two_line=0, busy=1, proto_err=0, drop_cnt=0, rd_char=0.
  - Internal: I/D=1, cg_mode=0, clear index=0.

## Timing
- A transfer committed at edge k updates ac, the status outputs, and DDRAM after edge k.
- rd_char latency is one cycle.
  - A read and a write to the same address at the same edge return the old data.
  - The new data is returned from the next edge onward.
- Clear command accepted at edge k:
  - busy=1 after edge k.
  - Locations 0..79 are filled at edges k+1..k+80.
  - busy falls after edge k+80.
  - Transfers at edges k+1..k+80 are dropped. A transfer at edge k+81 is accepted.
- Reset-entered clear:
  - busy deasserts 80 edges after rst releases.
  - Reset asserted mid-clear aborts it immediately. The clear restarts from index 0 on release.
- proto_err stays high for exactly one cycle per offending transfer.
  - Back-to-back offending transfers keep it high on consecutive cycles.

## Test plan
- Initialization sequence:
  - Stimulus: after busy falls, send 0x01 and wait 80 cycles, then send 0x38, 0x0C, 0x06, 0x80, followed by the 16 data bytes "   GAME START   ".
  - Required response: rd_addr 0x03..0x0C reads "GAME START", disp_on=1, two_line=1, ac=0x10.
- Line 2:
  - Stimulus: send 0xC0, then the data bytes "     TIMING: 07s".
  - Required response: DDRAM 0x45..0x4F reads "TIMING: 07s" and ac=0x50.
- Wrap-around:
  - Stimulus: set ac=0x27 and write 'A','B'. Then send 0x04, set ac=0x40, and write 'C','D'.
  - Required response: DDRAM 0x27='A', 0x40='B', 0x27='D' (overwrites 'A'), and ac=0x26.
- Busy drop:
  - Stimulus: send 0x01, then 5 data writes at edges k+1..k+5.
  - Required response: drop_cnt=5, every location reads 0x20, and a write at edge k+81 lands at 0x00.
- Protocol errors:
  - Stimulus: send 0xA8, a transfer with rw=1, and 0x40 followed by data 0x55.
  - Required response: two proto_err pulses, ac unchanged, and DDRAM unchanged.
- Reset mid-clear:
  - Stimulus: assert rst at cycle 40 of a clear, then release.
  - Required response: all outputs take their reset values, busy=1 for exactly 80 cycles after release, then every location reads 0x20.
